// File: rtl/merge_node_buffered.sv
// Two-input sorted-run merge node feeding an internal first-word-fall-through output FIFO.
// A zero key terminates a run; each pair of input runs produces one merged run and one terminator.
module merge_node_buffered #(
  parameter int W       = 32,
  parameter int DEPTH   = 16,
  parameter bit DESCEND = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W-1:0]     i_fifo_1,
  input  logic             i_fifo_1_empty,
  output logic             o_fifo_1_read,
  input  logic [W-1:0]     i_fifo_2,
  input  logic             i_fifo_2_empty,
  output logic             o_fifo_2_read,
  input  logic             i_deq,
  output logic [W-1:0]     o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_run_count
);
  localparam int AW = $clog2(DEPTH);

  // Handshake: every port pair is FWFT. A head is valid while its empty flag is 0, and a
  // read/deq strobe high at a rising edge consumes that head; strobes are never raised on empty.

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [AW:0]      count_nxt;
  logic             empty_q;
  logic             full_q;
  logic [CNT_W-1:0] run_count;

  logic             can_push;
  logic             both_ready;
  logic             h1;
  logic             h2;
  logic             s1_wins;
  logic             take1;
  logic             take2;
  logic             push;
  logic             pop;
  logic             run_done;
  logic [W-1:0]     push_key;

  always_comb begin
    can_push   = ~full_q | i_deq;
    both_ready = ~i_rst & can_push & ~i_fifo_1_empty & ~i_fifo_2_empty;
    h1         = (i_fifo_1 == '0);
    h2         = (i_fifo_2 == '0);
    s1_wins    = DESCEND ? (i_fifo_1 >= i_fifo_2) : (i_fifo_1 <= i_fifo_2);
    // A terminator on one side yields to any live key on the other; two terminators pop together.
    take1      = h2 | (~h1 & s1_wins);
    take2      = h1 | (~h2 & ~s1_wins);
    push       = both_ready;
    push_key   = take1 ? i_fifo_1 : i_fifo_2;
    run_done   = both_ready & h1 & h2;
    pop        = i_deq & ~empty_q;
  end

  assign o_fifo_1_read = both_ready & take1;
  assign o_fifo_2_read = both_ready & take2;

  always_comb begin
    count_nxt = count;
    if (push && !pop) begin
      count_nxt = count + 1'b1;
    end else if (!push && pop) begin
      count_nxt = count - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      run_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == (AW+1)'(DEPTH));
      if (run_done) begin
        run_count <= run_count + 1'b1;
      end
    end
  end

  // Storage is not reset; push is already gated off during reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= push_key;
    end
  end

  // Zero the head while empty so the output reads 0 out of reset without clearing storage.
  assign o_data      = empty_q ? '0 : mem[rd_ptr];
  assign o_empty     = empty_q;
  assign o_full      = full_q;
  assign o_run_count = run_count;

endmodule
